alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Four-phase MIPS R-type sequencer driving an external ALU, with a 32-entry register file.
// Define ALU_SEQUENCER_ILLEGAL_CHECK_EN to reject non-ALU instructions (no write, illegal pulse).
module alu_sequencer #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [2:0]        enable_fsm,
    output logic [5:0]        opcode,
    output logic [5:0]        function_code,
    output logic [DATA_W-1:0] n_in1,
    output logic [DATA_W-1:0] n_in2,
    input  logic [DATA_W-1:0] alu_result,
    output logic              done,
    output logic              illegal,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [2:0] {
        StIdle      = 3'b000,
        StDecode    = 3'b001,
        StExecute   = 3'b010,
        StWriteback = 3'b011
    } stateT;

    stateT             stateQ, stateD;
    logic [31:0]       instrQ;
    logic [DATA_W-1:0] regs [32];
    logic [5:0]        opcodeQ, functQ;
    logic [DATA_W-1:0] nIn1Q, nIn2Q;
    logic              doneQ;
    logic              accept, legal, writeEn;
    logic [4:0]        rsAddr, rtAddr, rdAddr;
    logic              unusedShamt;

    assign rsAddr      = instrQ[25:21];
    assign rtAddr      = instrQ[20:16];
    assign rdAddr      = instrQ[15:11];
    assign unusedShamt = ^instrQ[10:6];

    // Gated by reset_n so the handshake stays closed for the whole reset assertion.
    assign instr_ready = reset_n & (stateQ == StIdle);
    assign accept      = instr_valid & instr_ready;

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            StIdle:      if (accept) stateD = StDecode;
            StDecode:    stateD = StExecute;
            StExecute:   stateD = StWriteback;
            StWriteback: stateD = StIdle;
            default:     stateD = StIdle;
        endcase
    end

`ifdef ALU_SEQUENCER_ILLEGAL_CHECK_EN
    logic illegalQ;

    always_comb begin
        legal = 1'b0;
        if (instrQ[31:26] == 6'b000000) begin
            case (instrQ[5:0])
                6'b100000, 6'b100010, 6'b100110, 6'b100100, 6'b100101: legal = 1'b1;
                default: legal = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            illegalQ <= 1'b0;
        end else begin
            illegalQ <= (stateQ == StWriteback) && !legal;
        end
    end

    assign illegal = illegalQ;
`else
    assign legal   = 1'b1;
    assign illegal = 1'b0;
`endif

    assign writeEn = (stateQ == StWriteback) && (rdAddr != 5'd0) && legal;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stateQ  <= StIdle;
            instrQ  <= '0;
            opcodeQ <= '0;
            functQ  <= '0;
            nIn1Q   <= '0;
            nIn2Q   <= '0;
            doneQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            doneQ  <= (stateQ == StWriteback);
            if (accept) begin
                instrQ <= instr;
            end
            // ALU-facing fields only change here, so they hold through EXECUTE and beyond.
            if (stateQ == StDecode) begin
                opcodeQ <= instrQ[31:26];
                functQ  <= instrQ[5:0];
                nIn1Q   <= regs[rsAddr];
                nIn2Q   <= regs[rtAddr];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (writeEn) begin
            regs[rdAddr] <= alu_result;
        end
    end

    assign enable_fsm    = stateQ;
    assign opcode        = opcodeQ;
    assign function_code = functQ;
    assign n_in1         = nIn1Q;
    assign n_in2         = nIn2Q;
    assign done          = doneQ;
    assign dbg_data      = regs[dbg_addr];

endmodule
